cache_mem_arbiter: RTL
======================

// Module: cache_mem_arbiter
// PURPOSE
//  Sits directly downstream of icache and dcache. Arbitrates their single-word
//  RAM requests onto one shared RAM port and returns read data and wait status
//  to the requester. Data requests have priority; a streak limit prevents
//  instruction-fetch starvation. One transaction is in flight at a time.
// PARAMETERS
//  ADDR_W        32  address width (word_t address, byte addressed)
//  DATA_W        32  data width
//  MAX_D_STREAK  4   max consecutive D grants while iREN is pending (>=1)
// PORTS
//  CLK        in   1       clock, all state on posedge
//  RST        in   1       reset, synchronous, active-high
//  iREN       in   1       icache read request, held until iwait low
//  iaddr      in   ADDR_W  icache read address
//  iwait      out  1       0 only in the cycle iload is valid
//  iload      out  DATA_W  instruction word returned to icache
//  dREN       in   1       dcache read request
//  dWEN       in   1       dcache write request (wins over dREN if both high)
//  daddr      in   ADDR_W  dcache address
//  dstore     in   DATA_W  dcache write data
//  dwait      out  1       0 only in the cycle the D transaction completes
//  dload      out  DATA_W  read data returned to dcache
//  ram_req    out  1       RAM request, held until ram_ack
//  ram_wen    out  1       1 = write, 0 = read (valid while ram_req)
//  ram_addr   out  ADDR_W  latched request address
//  ram_wdata  out  DATA_W  latched write data
//  ram_rdata  in   DATA_W  RAM read data, valid with ram_ack
//  ram_ack    in   1       one-cycle completion pulse from RAM
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE, streak=0, ram_req=0, ram_wen=0, ram_addr/ram_wdata=0,
//   iwait=dwait=1, iload=dload=0. Reset mid-transaction aborts it:
//   ram_req is low the cycle after reset is sampled, and the RAM ack is ignored.
//  FSM states: IDLE, SERVE_I, SERVE_D.
//  IDLE:
//   - Goes to SERVE_D if (dREN|dWEN) and !(iREN && streak==MAX_D_STREAK).
//   - Otherwise goes to SERVE_I if iREN. Otherwise stays in IDLE.
//   - On a grant, latches addr, wdata, wen and the requester into registers.
//  SERVE_x:
//   - ram_req=1 with the latched fields.
//   - On ram_ack: the granted wait goes 0 combinationally in the same cycle,
//     and xload=ram_rdata (dload undefined-free: 0 on writes). Next state IDLE.
//  Latency: request seen in cycle N -> ram_req high in N+1 -> earliest ack in
//   N+1, with wait low in N+1. There is one IDLE bubble between transactions.
//  Stale requests: ack discarded, wait kept 1, FSM returns to IDLE and re-arbitrates.
//   - At the ack cycle, the live request must still be asserted, with address
//     equal to the latched address (for D: same wen).
//   - If not, the response is stale. The RAM transaction is never cut short.
//  Streak counter:
//   - On a D grant with iREN high: +1, saturating at MAX_D_STREAK.
//   - On a D grant with iREN low: cleared to 0.
//   - On an I grant: cleared to 0.
//  The non-granted requester always sees wait=1. ram_ack in IDLE is ignored.
//  Loads hold their last value except when updated. Width is pass-through; no arithmetic.
// TESTING
//  1 iREN=1 iaddr=0x40, RAM ack 2 cycles after ram_req, rdata=0xDEADBEEF
//    -> ram_req in cycle 1, ram_wen=0, iwait=0 and iload=0xDEADBEEF in cycle 3.
//  2 iREN and dREN both high from cycle 0 (addr 0x80/0x100), RAM acks at once
//    -> D served first, I granted immediately after; each wait low for exactly 1 cycle.
//  3 dWEN held high continuously with iREN=1, MAX_D_STREAK=4
//    -> 4 D writes, then 1 I read, then D resumes; streak returns to 0 after the I grant.
//  4 iaddr changes 0x40->0x44 while SERVE_I waits for ack
//    -> ack discarded, iwait stays 1; new grant issued for 0x44, which then completes.
//  5 RST high while SERVE_D with ram_req=1
//    -> next cycle ram_req=0, dwait=1, state IDLE; later ram_ack ignored.
//  6 dREN=dWEN=1, daddr=0x10, dstore=0x5
//    -> ram_wen=1, ram_wdata=0x5; dwait=0 on ack, dload=0.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache/RAM bus bundle for cache_mem_arbiter
// Purpose: groups the icache, dcache and shared-RAM signals of the arbiter.
// Ports (signals):
//   icache : iREN, iaddr (to arbiter); iwait, iload (from arbiter)
//   dcache : dREN, dWEN, daddr, dstore (to arbiter); dwait, dload (from arbiter)
//   RAM    : ram_req, ram_wen, ram_addr, ram_wdata (from arbiter);
//            ram_rdata, ram_ack (to arbiter)
// Modports: slave = arbiter view, master = environment (caches + RAM) view.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic              ram_req;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_rdata, ram_ack,
    output iwait, iload, dwait, dload, ram_req, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_rdata, ram_ack,
    input  iwait, iload, dwait, dload, ram_req, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - icache/dcache arbiter onto one shared RAM port
// Purpose: grants one single-word RAM transaction at a time, data side first,
//   with a streak limit so instruction fetches are not starved. Returns read
//   data and wait status to the granted cache; stale responses are dropped.
// Ports:
//   CLK  - clock, all state on posedge
//   RST  - synchronous active-high reset
//   bus  - cache_mem_arbiter_if.slave (icache, dcache and RAM signals)
module cache_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input logic                 CLK,
  input logic                 RST,
  cache_mem_arbiter_if.slave  bus
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t            state;
  logic [SW-1:0]     streak;
  logic              req_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] iload_q;
  logic [DATA_W-1:0] dload_q;

  logic d_any;
  logic d_pick;
  logic i_live;
  logic d_live;
  logic i_done;
  logic d_done;

  assign d_any  = bus.dREN | bus.dWEN;
  // D wins unless I is waiting and D has already had its full streak.
  assign d_pick = d_any && !(bus.iREN && (streak == STREAK_MAX));

  // A response is only delivered if the requester still wants the same word.
  assign i_live = bus.iREN && (bus.iaddr == addr_q);
  assign d_live = d_any && (bus.daddr == addr_q) && (bus.dWEN == wen_q);

  // Gated by RST so an ack landing in the reset cycle is never delivered.
  assign i_done = !RST && (state == SERVE_I) && bus.ram_ack && i_live;
  assign d_done = !RST && (state == SERVE_D) && bus.ram_ack && d_live;

  assign bus.iwait     = !i_done;
  assign bus.dwait     = !d_done;
  assign bus.iload     = i_done ? bus.ram_rdata : iload_q;
  assign bus.dload     = d_done ? (wen_q ? '0 : bus.ram_rdata) : dload_q;
  assign bus.ram_req   = req_q;
  assign bus.ram_wen   = wen_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      streak  <= '0;
      req_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_pick) begin
            state   <= SERVE_D;
            req_q   <= 1'b1;
            wen_q   <= bus.dWEN;
            addr_q  <= bus.daddr;
            wdata_q <= bus.dstore;
            if (bus.iREN)
              streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
            else
              streak <= '0;
          end else if (bus.iREN) begin
            state   <= SERVE_I;
            req_q   <= 1'b1;
            wen_q   <= 1'b0;
            addr_q  <= bus.iaddr;
            wdata_q <= '0;
            streak  <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          // The RAM transaction always runs to its ack, stale or not.
          if (bus.ram_ack) begin
            state <= IDLE;
            req_q <= 1'b0;
          end
          if (i_done) iload_q <= bus.ram_rdata;
          if (d_done) dload_q <= wen_q ? '0 : bus.ram_rdata;
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
